sar_search: RTL and testbench

- Successive-approximation search engine that drives the compare side of a magnitude comparator (cmp4-style a/b -> lt/eq/gt).
- It presents trial values and reads back the relation flags.
- It binary-searches the hidden operand on the other comparator input, MSB first, and reports the recovered value.
- It is the initiator/consumer for a comparator responder: the comparator maps values to a relation; this block maps relations back to a value.

---
 rtl/sar_search.sv | 138 +++++++++++++
 tb/tb_sar_search.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values into a comparator and binary-searches
// the hidden operand MSB first. Optional build macro SAR_EARLY_EXIT_EN ends the search on a valid eq.
module sar_search #(
  parameter int WIDTH    = 4,
  parameter int CMP_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(CMP_WAIT + 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] kept;
  logic             flags_ok;

  // The bit under test is already set in trial; gt means it overshot and must be dropped.
  assign bit_k    = WIDTH'(1) << k_q;
  assign kept     = gt ? (trial_q & ~bit_k) : trial_q;
  assign flags_ok = ({lt, eq, gt} == 3'b100) || ({lt, eq, gt} == 3'b010) ||
                    ({lt, eq, gt} == 3'b001);

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          trial_d  = WIDTH'(1) << (WIDTH - 1);
          k_d      = KW'(WIDTH - 1);
          cnt_d    = CW'(CMP_WAIT);
          busy_d   = 1'b1;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!flags_ok) begin
            err_d    = 1'b1;
            result_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else if (EARLY_EXIT && eq) begin
            result_d = trial_q;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else if (k_q == '0) begin
            result_d = kept;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            trial_d = kept | (bit_k >> 1);
            k_d     = k_q - KW'(1);
            cnt_d   = CW'(CMP_WAIT);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural cmp4 with a fixed target, vector table plus reset corner case.
module tb_sar_search;

  localparam int W = 4;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] trial;
  logic         lt, eq, gt;
  logic         busy, done, err;
  logic [W-1:0] result;

  logic [W-1:0] target;
  logic         inj;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0]        target;
    int                  inj_step;
    bit                  mid_start;
    int                  n_tr;
    logic [0:3][W-1:0]   tr;
    logic [W-1:0]        res;
    bit                  e;
  } vec_t;

  vec_t vecs[$];

  sar_search #(.WIDTH(W), .CMP_WAIT(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .trial  (trial),
    .lt     (lt),
    .eq     (eq),
    .gt     (gt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator responder; inj forces the illegal lt=gt=1 combination.
  always_comb begin
    lt = trial < target;
    eq = trial == target;
    gt = trial > target;
    if (inj) begin
      lt = 1'b1;
      eq = 1'b0;
      gt = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [W-1:0] tg, input int inj_step, input bit mid, input int n,
                     input logic [0:3][W-1:0] seq, input logic [W-1:0] res, input bit e);
    vec_t v;
    v.target = tg; v.inj_step = inj_step; v.mid_start = mid; v.n_tr = n;
    v.tr = seq; v.res = res; v.e = e;
    vecs.push_back(v);
  endtask

  // Independent reference: plain binary search of a value against the target.
  task automatic add_model(input logic [W-1:0] tg);
    logic [0:3][W-1:0] seq;
    logic [W-1:0]      val, t;
    int                n;
    seq = '0; val = '0; n = 0;
    for (int b = W - 1; b >= 0; b--) begin
      t = val | (W'(1) << b);
      seq[n] = t;
      n++;
      if (t <= tg) val = t;
      if (EARLY && t == tg) break;
    end
    add(tg, 0, 1'b0, n, seq, tg, 1'b0);
  endtask

  task automatic run(input vec_t v);
    logic [W:0] exp;
    int         cyc;
    bit         seen;
    target = v.target;
    exp_q.push_back({v.e, v.res});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cyc == 1) check("err_clear_on_start", err, 1'b0);
      if (cyc <= v.n_tr) begin
        check($sformatf("trial_t%0d_c%0d", v.target, cyc), trial, v.tr[cyc-1]);
        check("busy_during", busy, 1'b1);
      end
      inj   = (cyc == v.inj_step);
      start = v.mid_start && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    inj   = 1'b0;
    start = 1'b0;
    exp = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check($sformatf("latency_t%0d", v.target), cyc, v.n_tr + 1);
      check("busy_at_done", busy, 1'b0);
      check($sformatf("result_t%0d", v.target), {err, result}, exp);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("result_held", {err, result}, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    inj    = 1'b0;
    target = '0;
    repeat (3) @(negedge clk);
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    add(4'd0, 0, 1'b0, 4, {4'd8, 4'd4, 4'd2, 4'd1}, 4'd0, 1'b0);
    add(4'd15, 0, 1'b0, 4, {4'd8, 4'd12, 4'd14, 4'd15}, 4'd15, 1'b0);
    if (EARLY) add(4'd10, 0, 1'b0, 3, {4'd8, 4'd12, 4'd10, 4'd0}, 4'd10, 1'b0);
    else       add(4'd10, 0, 1'b0, 4, {4'd8, 4'd12, 4'd10, 4'd11}, 4'd10, 1'b0);
    add(4'd6, 2, 1'b0, 2, {4'd8, 4'd4, 4'd0, 4'd0}, 4'd0, 1'b1);
    if (EARLY) add(4'd6, 0, 1'b0, 3, {4'd8, 4'd4, 4'd6, 4'd0}, 4'd6, 1'b0);
    else       add(4'd6, 0, 1'b0, 4, {4'd8, 4'd4, 4'd6, 4'd7}, 4'd6, 1'b0);
    add(4'd5, 0, 1'b1, 4, {4'd8, 4'd4, 4'd6, 4'd5}, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) add_model(W'($urandom_range(0, 15)));

    foreach (vecs[i]) run(vecs[i]);

    // Reset during the third step of a search for 9.
    target = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_trial", trial, 4'd10);
    rst_n = 1'b0;
    #1;
    check("async_rst_trial", trial, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
      check("idle_after_rst", busy, 0);
    end
    add(4'd9, 0, 1'b0, 4, {4'd8, 4'd12, 4'd10, 4'd9}, 4'd9, 1'b0);
    run(vecs[vecs.size()-1]);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
